// File: rtl/mem_copy_dma_pkg.sv
// Shared definitions for the word-copy DMA and the data memory it drives:
// FSM encoding, size defaults, forbidden address region and address helper.
package mem_copy_dma_pkg;

  localparam int MAX_WORDS_DEFAULT = 256;
  localparam int CNT_BITS_DEFAULT  = 9;

  // Top nibble of any address the engine must never strobe.
  localparam logic [3:0] FORBIDDEN_REGION = 4'h4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_RD    = 3'd2,
    S_WR    = 3'd3,
    S_FIN   = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  // Byte address of word idx relative to base; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [29:0] idx);
    return base + {idx, 2'b00};
  endfunction

endpackage

// File: rtl/mem_copy_dma_addr_check.sv
// Combinational address legality check: word alignment and forbidden region.
// Only the bits that matter are passed in (top nibble and byte offset).
module addr_check
  import mem_copy_dma_pkg::*;
(
  input  logic [3:0] addr_hi,
  input  logic [1:0] addr_lo,
  output logic       misaligned,
  output logic       forbidden
);

  assign misaligned = (addr_lo != 2'b00);
  assign forbidden  = (addr_hi == FORBIDDEN_REGION);

endmodule

// File: rtl/mem_copy_dma.sv
// Single-channel memory-to-memory word copy engine with one read/write pair
// per word, alignment/length/forbidden-region checking and a sticky error.
module mem_copy_dma
  import mem_copy_dma_pkg::*;
#(
  parameter int MAX_WORDS = MAX_WORDS_DEFAULT,
  parameter int CNT_BITS  = CNT_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [31:0]         src_addr,
  input  logic [31:0]         dst_addr,
  input  logic [CNT_BITS-1:0] word_cnt,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata
);

  // Request handshake: start is a level sampled only while busy=0; the edge
  // that sees start=1 in IDLE accepts the request, anything while busy is dropped.

  state_t              state_q, state_d;
  logic [31:0]         src_q, dst_q, hold_q;
  logic [CNT_BITS-1:0] cnt_q, i_q, i_next;
  logic                err_q;

  logic [31:0] rd_addr, wr_addr;
  logic        src_misaligned, src_forbidden;
  logic        dst_misaligned, dst_forbidden;
  logic        cnt_too_big, cnt_zero, last_word;

  assign rd_addr     = word_addr(src_q, 30'(i_q));
  assign wr_addr     = word_addr(dst_q, 30'(i_q));
  assign i_next      = i_q + CNT_BITS'(1);
  assign last_word   = (i_next == cnt_q);
  assign cnt_zero    = (cnt_q == '0);
  assign cnt_too_big = (32'(cnt_q) > 32'(MAX_WORDS));

  // With i=0 in CHECK these see the latched base addresses, so the same
  // instances serve the alignment check and the per-strobe region check.
  addr_check u_src_check (
    .addr_hi   (rd_addr[31:28]),
    .addr_lo   (rd_addr[1:0]),
    .misaligned(src_misaligned),
    .forbidden (src_forbidden)
  );

  addr_check u_dst_check (
    .addr_hi   (wr_addr[31:28]),
    .addr_lo   (wr_addr[1:0]),
    .misaligned(dst_misaligned),
    .forbidden (dst_forbidden)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (src_misaligned || dst_misaligned || cnt_too_big) state_d = S_ERR;
        else if (cnt_zero)                                   state_d = S_FIN;
        else                                                 state_d = S_RD;
      end
      S_RD: begin
        if (src_forbidden) state_d = S_ERR;
        else               state_d = S_WR;
      end
      S_WR: begin
        if (dst_forbidden)  state_d = S_ERR;
        else if (last_word) state_d = S_FIN;
        else                state_d = S_RD;
      end
      S_FIN:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are suppressed in the very cycle a forbidden address is seen.
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_FIN);
    err       = err_q;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_RD: begin
        if (!src_forbidden) begin
          mem_rd   = 1'b1;
          mem_addr = rd_addr;
        end
      end
      S_WR: begin
        if (!dst_forbidden) begin
          mem_wr    = 1'b1;
          mem_addr  = wr_addr;
          mem_wdata = hold_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q  <= '0;
      dst_q  <= '0;
      cnt_q  <= '0;
      i_q    <= '0;
      hold_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start) begin
        src_q <= src_addr;
        dst_q <= dst_addr;
        cnt_q <= word_cnt;
        i_q   <= '0;
        err_q <= 1'b0;
      end
      if (state_q == S_RD && !src_forbidden) begin
        hold_q <= mem_rdata;
      end
      if (state_q == S_WR && !dst_forbidden) begin
        i_q <= i_next;
      end
      if (state_d == S_ERR) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma: 4 KiB word memory model aliased on
// addr[11:2], strobe logs, and hand-computed expectations per step.
module tb_mem_copy_dma;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] src_addr, dst_addr;
  logic [8:0]  word_cnt;
  logic        busy, done, err, mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;
  int idle_bus_cnt = 0;
  int d0;

  logic [31:0] mem [0:1023] = '{default: 32'h0};
  logic        pl_en = 1'b0;
  logic [9:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;
  logic [31:0] rd_log[$];
  logic [31:0] wr_log[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mem_copy_dma dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .word_cnt (word_cnt),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[11:2]];

  // Memory model and bus monitor.
  always @(posedge clk) begin
    if (mem_wr)     mem[mem_addr[11:2]] <= mem_wdata;
    else if (pl_en) mem[pl_idx] <= pl_data;
    if (mem_rd) rd_log.push_back(mem_addr);
    if (mem_wr) wr_log.push_back(mem_addr);
    if (done) done_cnt++;
    if (mem_rd && mem_wr) overlap_cnt++;
    if (!mem_rd && !mem_wr && (mem_addr != 32'h0 || mem_wdata != 32'h0)) idle_bus_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    step();
    pl_en = 1'b0;
  endtask

  // Presents a request for one edge; afterwards cyc=1 is the CHECK cycle.
  task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [8:0] n);
    rd_log.delete();
    wr_log.delete();
    src_addr = s; dst_addr = d; word_cnt = n; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_done(input int limit);
    while (!done && cyc < limit) step();
    chk("done_seen", 32'(done), 32'h1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    src_addr = '0; dst_addr = '0; word_cnt = '0;
    step();
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_done",  32'(done), 32'h0);
    chk("rst_err",   32'(err), 32'h0);
    chk("rst_rdwr",  {30'h0, mem_rd, mem_wr}, 32'h0);
    chk("rst_addr",  mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    reset = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 32'h0);

    // Basic 4-word copy with cycle-exact timing.
    for (int k = 0; k < 4; k++) preload(10'(k), 32'(k + 1));
    kick(32'h0, 32'h100, 9'd4);
    chk("cp_check_busy", 32'(busy), 32'h1);
    chk("cp_check_strb", {30'h0, mem_rd, mem_wr}, 32'h0);
    step();
    chk("cp_rd0", {30'h0, mem_rd, mem_wr}, 32'h2);
    chk("cp_rd0_addr", mem_addr, 32'h0);
    step();
    chk("cp_wr0", {30'h0, mem_rd, mem_wr}, 32'h1);
    chk("cp_wr0_addr", mem_addr, 32'h100);
    chk("cp_wr0_data", mem_wdata, 32'h1);
    wait_done(20);
    chk("cp_done_cyc", 32'(cyc), 32'd10);
    chk("cp_err", 32'(err), 32'h0);
    step();
    chk("cp_done_pulse", 32'(done), 32'h0);
    chk("cp_busy_after", 32'(busy), 32'h0);
    for (int k = 0; k < 4; k++) chk("cp_mem", mem[10'h40 + 10'(k)], 32'(k + 1));
    chk("cp_wr_count", 32'(wr_log.size()), 32'd4);

    // Zero-length transfer.
    kick(32'h10, 32'h20, 9'd0);
    chk("zl_busy1", 32'(busy), 32'h1);
    wait_done(10);
    chk("zl_done_cyc", 32'(cyc), 32'd2);
    chk("zl_busy2", 32'(busy), 32'h1);
    step();
    chk("zl_busy3", 32'(busy), 32'h0);
    chk("zl_strobes", 32'(rd_log.size() + wr_log.size()), 32'h0);

    // Misaligned source.
    d0 = done_cnt;
    kick(32'h2, 32'h100, 9'd4);
    step();
    chk("ms_err_state", {30'h0, busy, err}, 32'h3);
    step();
    step();
    step();
    chk("ms_err_sticky", {30'h0, busy, err}, 32'h1);
    chk("ms_strobes", 32'(rd_log.size() + wr_log.size()), 32'h0);
    chk("ms_no_done", 32'(done_cnt - d0), 32'h0);

    // Destination runs into the forbidden region after two words.
    d0 = done_cnt;
    kick(32'h0, 32'h3FFFFFF8, 9'd4);
    chk("fb_err_cleared", 32'(err), 32'h0);
    while (cyc < 8) step();
    chk("fb_err_state", {30'h0, busy, err}, 32'h3);
    step();
    chk("fb_idle", {30'h0, busy, err}, 32'h1);
    chk("fb_wr_count", 32'(wr_log.size()), 32'd2);
    chk("fb_last_wr", wr_log[wr_log.size() - 1], 32'h3FFFFFFC);
    chk("fb_rd_count", 32'(rd_log.size()), 32'd3);
    chk("fb_mem0", mem[10'h3FE], 32'h1);
    chk("fb_mem1", mem[10'h3FF], 32'h2);
    chk("fb_alias_untouched", mem[10'h000], 32'h1);
    chk("fb_no_done", 32'(done_cnt - d0), 32'h0);

    // Reset during the write of word 2 of an 8-word copy.
    for (int k = 0; k < 8; k++) preload(10'h80 + 10'(k), 32'hA0 + 32'(k));
    kick(32'h200, 32'h300, 9'd8);
    while (cyc < 7) step();
    chk("ra_in_wr2", {30'h0, mem_rd, mem_wr}, 32'h1);
    chk("ra_wr2_addr", mem_addr, 32'h308);
    #1 reset = 1'b1;
    #1;
    chk("ra_strobes", {30'h0, mem_rd, mem_wr}, 32'h0);
    chk("ra_addr", mem_addr, 32'h0);
    chk("ra_busy", 32'(busy), 32'h0);
    #1 reset = 1'b0;
    step();
    step();
    step();
    chk("ra_still_idle", 32'(busy), 32'h0);
    chk("ra_wr_count", 32'(wr_log.size()), 32'd2);
    chk("ra_w0", mem[10'hC0], 32'hA0);
    chk("ra_w1", mem[10'hC1], 32'hA1);
    chk("ra_w2", mem[10'hC2], 32'h0);
    chk("ra_w7", mem[10'hC7], 32'h0);

    // Start pulsed mid-transfer must be ignored.
    kick(32'h0, 32'h180, 9'd3);
    while (cyc < 3) step();
    src_addr = 32'h200; dst_addr = 32'h380; word_cnt = 9'd5; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(20);
    chk("bs_done_cyc", 32'(cyc), 32'd8);
    step();
    step();
    step();
    chk("bs_not_queued", 32'(busy), 32'h0);
    chk("bs_wr_count", 32'(wr_log.size()), 32'd3);
    chk("bs_first_wr", wr_log[0], 32'h180);
    for (int k = 0; k < 3; k++) chk("bs_mem", mem[10'h60 + 10'(k)], 32'(k + 1));
    chk("bs_mem3", mem[10'h63], 32'h0);
    chk("bs_other_dst", mem[10'hE0], 32'h0);

    // Source wraps past the top of the address space.
    preload(10'h3FE, 32'h11);
    preload(10'h3FF, 32'h22);
    preload(10'h000, 32'h33);
    exp_q = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000};
    kick(32'hFFFFFFF8, 32'h400, 9'd3);
    wait_done(20);
    chk("wr_done_cyc", 32'(cyc), 32'd8);
    chk("wr_err", 32'(err), 32'h0);
    chk("wr_rd_count", 32'(rd_log.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && rd_log.size() > 0) chk("wr_rd_addr", rd_log.pop_front(), exp_q.pop_front());
    step();
    chk("wr_m0", mem[10'h100], 32'h11);
    chk("wr_m1", mem[10'h101], 32'h22);
    chk("wr_m2", mem[10'h102], 32'h33);

    chk("bus_overlap", 32'(overlap_cnt), 32'h0);
    chk("bus_idle_quiet", 32'(idle_bus_cnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_copy_dma.md
MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 256, the maximum transfer length in words.
REQ-002 SHALL have parameter CNT_BITS, default 9, the width of the length and counter fields (holds 0..MAX_WORDS).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request a transfer; sampled only in IDLE.
REQ-006 SHALL have port src_addr, input, 32 bits: source byte address of word 0.
REQ-007 SHALL have port dst_addr, input, 32 bits: destination byte address of word 0.
REQ-008 SHALL have port word_cnt, input, CNT_BITS bits: number of words to copy.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at successful completion.
REQ-011 SHALL have port err, output, 1 bit: sticky error flag.
REQ-012 SHALL have port mem_rd, output, 1 bit: data-memory read strobe.
REQ-013 SHALL have port mem_wr, output, 1 bit: data-memory write strobe.
REQ-014 SHALL have port mem_addr, output, 32 bits: word-aligned data-memory address.
REQ-015 SHALL have port mem_wdata, output, 32 bits: data-memory write data.
REQ-016 SHALL have port mem_rdata, input, 32 bits: data-memory read data; combinational, valid in the same cycle as mem_rd.

Function
REQ-017 SHALL implement the states IDLE, CHECK, RD, WR, FIN and ERR.
REQ-018 In IDLE, when start=1, the block SHALL latch src_addr, dst_addr and word_cnt, clear err, clear the word index i to 0, and go to CHECK.
REQ-019 In CHECK, the block SHALL go to ERR if src[1:0]!=0, dst[1:0]!=0, or word_cnt>MAX_WORDS; SHALL go to FIN if word_cnt=0; and SHALL go to RD otherwise.
REQ-020 In RD, the block SHALL drive mem_rd=1 and mem_addr=src+4*i, capture mem_rdata into a 32-bit holding register at the clock edge, and go to WR.
REQ-021 In WR, the block SHALL drive mem_wr=1, mem_addr=dst+4*i and mem_wdata=holding register, then increment i and go to FIN if i+1=word_cnt, or to RD otherwise.
REQ-022 Before asserting mem_rd or mem_wr, the block SHALL check the address; if mem_addr[31:28]=4'h4, it SHALL suppress the strobe in that cycle and go to ERR.
REQ-023 Address arithmetic SHALL be 32-bit modulo 2^32; wrap past 0xFFFFFFFC continues at 0x00000000 without error.
REQ-024 In FIN, the block SHALL assert done=1 for exactly one cycle and then go to IDLE.
REQ-025 In ERR, the block SHALL set err=1 and go to IDLE next cycle; err SHALL hold until the next accepted start or reset; done SHALL not pulse.
REQ-026 mem_rd and mem_wr SHALL never be high in the same cycle; both SHALL be 0 outside RD/WR.
REQ-027 mem_addr and mem_wdata SHALL be 0 whenever no strobe is asserted.
REQ-028 Timing: with start sampled at edge T and N>0, CHECK SHALL occupy cycle T+1, RD/WR pairs SHALL occupy cycles T+2 .. T+2N+1, and done SHALL be high in cycle T+2N+2.
REQ-029 A start asserted while busy=1 SHALL be ignored and not queued.
REQ-030 Overlapping ranges SHALL be copied in ascending address order; the result is whatever that order produces.

Reset
REQ-031 While reset=1, the block SHALL asynchronously force state=IDLE, i=0, holding register=0, and busy=done=err=mem_rd=mem_wr=0 with mem_addr=mem_wdata=0.
REQ-032 A reset mid-transfer SHALL abort the transfer immediately with no further strobes; words already written SHALL remain in memory.

Structure
REQ-033 The state encoding, MAX_WORDS/CNT_BITS defaults and the forbidden-region constant 4'h4 SHALL live in a shared package used by this block and the data memory.
REQ-034 The address-legality check (alignment plus forbidden region) SHALL be one small combinational sub-module, addr_check, instantiated for the source and destination addresses.
REQ-035 The block SHALL contain no other sub-modules; the memory SHALL be external.

Verification
REQ-036 Copy test: preload mem[0x00..0x0C]=1,2,3,4, then start with src=0, dst=0x100, cnt=4 -> mem[0x100..0x10C]=1,2,3,4, done high in cycle T+10, err=0.
REQ-037 Zero-length test: start with cnt=0 -> no strobes, done high in cycle T+2, busy high for cycles T+1..T+2.
REQ-038 Error tests: start with src=0x2 -> err=1, no strobes, no done; start with dst=0x3FFFFFF8, cnt=4 -> two words written, then err=1 with no write to 0x40000000.
REQ-039 Reset abort: assert reset during WR of word 2 of an 8-word copy -> strobes drop the same cycle, busy=0, words 0-1 copied, word 2 and later untouched.
REQ-040 Busy-start test: pulse start during a transfer with different src/dst/cnt -> ignored, and the original transfer completes with its original values.
REQ-041 Wrap test: start with src=0xFFFFFFF8, cnt=3 -> reads at 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 with no error.
